// File: rtl/usb_rx_pkg.sv
// USB receive control: shared types and constants.
// State encoding, SYNC pattern and the state->rcving decode.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    DATA_RCV,
    DATA_WR,
    NOMATCH,
    EOP_WAIT,
    EIDLE
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // A packet is in progress everywhere except
  // the two resting states.
  function automatic logic rcv_active(
    input rx_state_t s
  );
    return !((s == IDLE) || (s == EIDLE));
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Destuffed-bit counter with registered byte-ready pulse.
// Ports: clk, n_rst, clear, count_en in; bit_cnt[2:0], byte_rdy out.
module rx_bit_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       count_en,
  output logic [2:0] bit_cnt,
  output logic       byte_rdy
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt  <= 3'd0;
      byte_rdy <= 1'b0;
    end else begin
      // Pulse follows the shift that wraps 7->0,
      // so the shift register holds a whole byte.
      byte_rdy <= count_en && !clear &&
                  (bit_cnt == 3'd7);
      if (clear || byte_rdy) begin
        bit_cnt <= 3'd0;
      end else if (count_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive control FSM: SYNC check, byte writes, EOP/error.
// In: clk, n_rst, d_edge, eop, shift_en, byte_data[7:0]; out: rcving, w_enable, r_error, byte_cnt[6:0].
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = 67
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_en,
  input  logic [7:0] byte_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [6:0] byte_cnt
);

  localparam logic [6:0] CNT_MAX = 7'(MAX_BYTES);

  rx_state_t  state;
  rx_state_t  nxt;
  logic [2:0] bit_cnt;
  logic       byte_rdy;
  logic       count_en;
  logic       sync_entry;
  logic       err_entry;
  logic       cnt_full;
  logic       wr_go;

  assign count_en   = shift_en &&
                      ((state == SYNC_RCV) ||
                       (state == DATA_RCV));
  assign sync_entry = (nxt == SYNC_RCV) &&
                      (state != SYNC_RCV);
  assign err_entry  = (nxt == NOMATCH) &&
                      (state != NOMATCH);
  assign cnt_full   = (byte_cnt == CNT_MAX);
  // A byte headed for DATA_WR is only written
  // while the packet is still within length.
  assign wr_go      = (state == DATA_RCV) &&
                      (nxt == DATA_WR) &&
                      !cnt_full;

  rx_bit_counter u_bits (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (sync_entry),
    .count_en (count_en),
    .bit_cnt  (bit_cnt),
    .byte_rdy (byte_rdy)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (d_edge) nxt = SYNC_RCV;
      end
      SYNC_RCV: begin
        if (byte_rdy) nxt = SYNC_CHK;
        else if (eop) nxt = NOMATCH;
      end
      SYNC_CHK: begin
        if (byte_data == SYNC_BYTE) nxt = DATA_RCV;
        else nxt = NOMATCH;
      end
      DATA_RCV: begin
        // A completed byte wins over a same-cycle
        // EOP; EOP is seen again next DATA_RCV cycle.
        if (byte_rdy) begin
          nxt = DATA_WR;
        end else if (eop) begin
          if (bit_cnt == 3'd0) nxt = EOP_WAIT;
          else nxt = NOMATCH;
        end
      end
      DATA_WR: begin
        // No strobe here means the byte overflowed.
        if (w_enable) nxt = DATA_RCV;
        else nxt = NOMATCH;
      end
      NOMATCH: begin
        if (!eop && d_edge) nxt = EIDLE;
      end
      EOP_WAIT: begin
        if (d_edge) nxt = IDLE;
      end
      EIDLE: begin
        if (d_edge) nxt = SYNC_RCV;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rcving   <= 1'b0;
      w_enable <= 1'b0;
      r_error  <= 1'b0;
      byte_cnt <= 7'd0;
    end else begin
      state    <= nxt;
      rcving   <= rcv_active(nxt);
      w_enable <= wr_go;
      if (sync_entry) begin
        byte_cnt <= 7'd0;
      end else if (wr_go) begin
        byte_cnt <= byte_cnt + 7'd1;
      end
      if (err_entry) begin
        r_error <= 1'b1;
      end else if (sync_entry) begin
        r_error <= 1'b0;
      end
    end
  end

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 67, meaning the maximum post-SYNC bytes per packet (PID + 64 data + CRC16).
REQ-002 SHALL have clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have d_edge  input  1  single-cycle pulse on any decoded-line transition.
REQ-005 SHALL have eop  input  1  level, high while SE0 is sampled on the bus.
REQ-006 SHALL have shift_en  input  1  single-cycle pulse, identical to the shift-register shift enable; one pulse per destuffed bit.
REQ-007 SHALL have byte_data  input  8  output of the 8-bit LSB-first receive shift register; first bit received ends in bit 0.
REQ-008 SHALL have rcving  output  1  high while a packet is in progress.
REQ-009 SHALL have w_enable  output  1  single-cycle FIFO write strobe; FIFO samples byte_data in the same cycle.
REQ-010 SHALL have r_error  output  1  sticky packet-error flag.
REQ-011 SHALL have byte_cnt  output  7  count of data bytes written in the current packet.

Function
REQ-012 SHALL hold a 3-bit bit counter, cleared on entry to SYNC_RCV and on each byte_rdy, incremented on shift_en in SYNC_RCV and DATA_RCV, wrapping 7->0.
REQ-013 SHALL generate internal byte_rdy, registered, high one cycle after the shift_en that moves the bit counter from 7 to 0; byte_data is then stable and holds the complete byte.
REQ-014 SHALL implement states IDLE, SYNC_RCV, SYNC_CHK, DATA_RCV, DATA_WR, NOMATCH, EOP_WAIT, EIDLE.
REQ-015 IDLE: d_edge -> SYNC_RCV.
REQ-016 SYNC_RCV: byte_rdy -> SYNC_CHK; eop -> NOMATCH.
REQ-017 SYNC_CHK: one cycle; byte_data == SYNC_BYTE (8'h80) -> DATA_RCV, else -> NOMATCH.
REQ-018 DATA_RCV: byte_rdy -> DATA_WR; eop with bit counter == 0 -> EOP_WAIT; eop with bit counter != 0 -> NOMATCH (partial byte).
REQ-019 DATA_WR: one cycle; w_enable = 1; byte_cnt increments; next state DATA_RCV. If byte_cnt already equals MAX_BYTES, w_enable = 0 and next state NOMATCH.
REQ-020 NOMATCH: r_error set; on eop deasserted with a d_edge -> EIDLE; stays while eop is high or the line is idle.
REQ-021 EOP_WAIT: on d_edge (SE0 -> J) -> IDLE; r_error unchanged.
REQ-022 EIDLE: r_error held at 1; d_edge -> SYNC_RCV with r_error cleared.
REQ-023 r_error SHALL also clear on the IDLE -> SYNC_RCV transition; it is set only on entry to NOMATCH.
REQ-024 rcving SHALL be 1 in SYNC_RCV, SYNC_CHK, DATA_RCV, DATA_WR, NOMATCH and EOP_WAIT, and 0 in IDLE and EIDLE.
REQ-025 byte_cnt SHALL clear on entry to SYNC_RCV, saturate at MAX_BYTES, and hold its value after the packet until the next SYNC_RCV entry.
REQ-026 When eop and byte_rdy coincide in DATA_RCV, byte_rdy SHALL take priority: the byte is written, and eop is evaluated in the following DATA_RCV cycle.
REQ-027 A d_edge in any state other than IDLE, EOP_WAIT or EIDLE SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from the registered state only; no input-to-output combinational path.

Reset
REQ-029 n_rst low SHALL force state IDLE, bit counter 0, byte_rdy 0, byte_cnt 0, rcving 0, w_enable 0 and r_error 0, regardless of clk.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no w_enable; after release the block waits for d_edge in IDLE.

Structure
REQ-031 Package usb_rx_pkg SHALL hold the state enum type and the constant SYNC_BYTE = 8'h80.
REQ-032 The bit counter and byte_rdy generation SHALL be the sub-module rx_bit_counter (ports: clk, n_rst, clear, count_en, bit_cnt[2:0], byte_rdy).

Verification
REQ-033 Valid packet: SYNC 8'h80, then bytes 8'hC3, 8'h01, 8'h02, then eop at a byte boundary and a d_edge -> three w_enable pulses, byte_cnt = 3, r_error = 0, rcving falls on return to IDLE.
REQ-034 Bad SYNC: first byte 8'h81 -> NOMATCH, r_error = 1, no w_enable; the next d_edge after eop starts a clean packet and clears r_error.
REQ-035 Partial byte: eop after 4 bits of a data byte -> r_error = 1, byte_cnt unchanged.
REQ-036 Overlength: 68 data bytes with MAX_BYTES = 67 -> 67 writes, r_error = 1 on the 68th byte.
REQ-037 Coincidence: eop asserted in the same cycle as byte_rdy -> the byte is written and the packet ends without error.
REQ-038 Reset pulse during the 2nd data byte -> all outputs 0 immediately; the next packet is received correctly.
